seq_muldiv: RTL and testbench

- Iterative integer multiply/divide unit; responder side of the ALU's op/q/busy/dn coprocessor handshake (same protocol the FPU path uses).
- Lets the ALU offload MUL/DIV to a small shift-add / restoring-divide engine instead of single-cycle `*` and `/`.
- Advances only on clk edges where clk_oe=1, matching the ALU's half-rate enable.

---
 rtl/seq_muldiv_pkg.sv | 27 ++
 rtl/seq_muldiv_step.sv | 33 +++
 rtl/seq_muldiv.sv | 171 +++++++++++++++++
 tb/tb_seq_muldiv.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seq_muldiv_pkg.sv
// Shared opcodes and FSM state encodings for the iterative multiply/divide unit.
// Operand width is the only tunable; it tracks the datapath width.
package seq_muldiv_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [1:0] MD_OP_MULU = 2'd0;
   localparam logic [1:0] MD_OP_MULS = 2'd1;
   localparam logic [1:0] MD_OP_DIVU = 2'd2;
   localparam logic [1:0] MD_OP_DIVS = 2'd3;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/seq_muldiv_step.sv
// One radix-2 iteration: a shift-add multiply step and a restoring divide step.
// Both results are produced every cycle; the caller keeps the one it needs.
module seq_muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   opnd_i,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH:0]     rem_i,
   input  logic [WIDTH-1:0]   quot_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic [WIDTH:0]     rem_o,
   output logic [WIDTH-1:0]   quot_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH+1:0] shl;
   logic [WIDTH+1:0] diff;
   logic             ge;

   always_comb begin
      sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
          + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
      acc_o = {sum, acc_i[WIDTH-1:1]};

      // Borrow out of the extra top bit tells whether the trial subtract fits.
      shl    = {rem_i, quot_i[WIDTH-1]};
      diff   = shl - {2'b00, opnd_i};
      ge     = ~diff[WIDTH+1];
      rem_o  = ge ? diff[WIDTH:0] : shl[WIDTH:0];
      quot_o = {quot_i[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/seq_muldiv.sv
// Iterative MUL/DIV coprocessor on the ALU op/q/busy/dn handshake.
// Works on magnitudes, then fixes signs in a dedicated state; fixed latency.
module seq_muldiv
   import seq_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_oe,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             q,
   output logic             busy,
   output logic             dn,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_h,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               busy_q, busy_d;
   logic               dn_q, dn_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   out_h_q, out_h_d;
   logic               dz_q, dz_d;

   logic [2*WIDTH-1:0] acc_s;
   logic [WIDTH:0]     rem_s;
   logic [WIDTH-1:0]   quot_s;

   logic               sa, sb;
   logic [WIDTH-1:0]   ma, mb;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot_f, rem_f;

   seq_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .opnd_i (opnd_q),
      .acc_i  (acc_q),
      .rem_i  (rem_q),
      .quot_i (quot_q),
      .acc_o  (acc_s),
      .rem_o  (rem_s),
      .quot_o (quot_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      opnd_d  = opnd_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      busy_d  = busy_q;
      dn_d    = dn_q;
      out_d   = out_q;
      out_h_d = out_h_q;
      dz_d    = dz_q;

      // Two's-complement negate maps the minimum value onto 2^(WIDTH-1).
      sa = op_is_signed(op) & a[WIDTH-1];
      sb = op_is_signed(op) & b[WIDTH-1];
      ma = sa ? -a : a;
      mb = sb ? -b : b;

      prod   = neg_q ? -acc_q : acc_q;
      quot_f = neg_q ? -quot_q : quot_q;
      rem_f  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

      unique case (state_q)
         MD_IDLE: begin
            if (q) begin
               op_d    = op;
               neg_d   = sa ^ sb;
               rneg_d  = sa;
               acc_d   = {{WIDTH{1'b0}}, mb};
               rem_d   = '0;
               quot_d  = ma;
               opnd_d  = op_is_div(op) ? mb : ma;
               cnt_d   = CW'(WIDTH - 1);
               busy_d  = 1'b1;
               state_d = MD_CALC;
            end
         end
         MD_CALC: begin
            if (op_is_div(op_q)) begin
               rem_d  = rem_s;
               quot_d = quot_s;
            end else begin
               acc_d = acc_s;
            end
            if (cnt_q == '0) state_d = MD_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         MD_FIX: begin
            if (op_is_div(op_q)) begin
               dz_d    = (opnd_q == '0);
               out_d   = (opnd_q == '0) ? {WIDTH{1'b1}} : quot_f;
               out_h_d = rem_f;
            end else begin
               dz_d    = 1'b0;
               out_d   = prod[WIDTH-1:0];
               out_h_d = prod[2*WIDTH-1:WIDTH];
            end
            dn_d    = 1'b1;
            state_d = MD_DONE;
         end
         MD_DONE: begin
            dn_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         opnd_q  <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         dn_q    <= 1'b0;
         out_q   <= '0;
         out_h_q <= '0;
         dz_q    <= 1'b0;
      end else if (clk_oe) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         opnd_q  <= opnd_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         busy_q  <= busy_d;
         dn_q    <= dn_d;
         out_q   <= out_d;
         out_h_q <= out_h_d;
         dz_q    <= dz_d;
      end
   end

   assign busy  = busy_q;
   assign dn    = dn_q;
   assign out   = out_q;
   assign out_h = out_h_q;
   assign dz    = dz_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv: arithmetic vectors, latency, q toggling,
// clock-enable freeze and mid-operation reset.
module tb_seq_muldiv;

   logic        clk;
   logic        rst;
   logic        clk_oe;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        q;
   logic        busy;
   logic        dn;
   logic [31:0] out;
   logic [31:0] out_h;
   logic        dz;

   int n_run;
   int n_fail;

   seq_muldiv #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .clk_oe (clk_oe),
      .op     (op),
      .a      (a),
      .b      (b),
      .q      (q),
      .busy   (busy),
      .dn     (dn),
      .out    (out),
      .out_h  (out_h),
      .dz     (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // mode: 0 plain, 1 toggle q while busy, 2 clk_oe freeze, 3 reset at cnt=10
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input int mode, input logic [31:0] e_lo,
                         input logic [31:0] e_hi, input logic e_dz);
      int lat;
      int extra;
      @(negedge clk);
      op = o; a = x; b = y; q = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
      if (mode != 1) q = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         if (mode == 1) q = ~q;
         if (mode == 2 && lat == 10) begin
            clk_oe = 1'b0;
            repeat (5) @(negedge clk);
            chk({tag, "_frz_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_frz_dn"}, {31'd0, dn}, 32'd0);
            clk_oe = 1'b1;
         end
         @(posedge clk); #1;
         lat++;
         if (mode == 3 && lat == 21) begin
            rst = 1'b0;
            #1;
            chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_rst_dn"}, {31'd0, dn}, 32'd0);
            chk({tag, "_rst_out"}, out, 32'd0);
            chk({tag, "_rst_outh"}, out_h, 32'd0);
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         if (dn) break;
      end
      q = 1'b0;
      chk({tag, "_lat"}, lat, 32'd33);
      chk({tag, "_out"}, out, e_lo);
      chk({tag, "_outh"}, out_h, e_hi);
      chk({tag, "_dz"}, {31'd0, dz}, {31'd0, e_dz});
      @(posedge clk); #1;
      chk({tag, "_dn_pulse"}, {31'd0, dn}, 32'd0);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      if (mode == 1) begin
         extra = 0;
         repeat (40) begin
            @(posedge clk); #1;
            if (dn) extra++;
         end
         chk({tag, "_extra_dn"}, extra, 32'd0);
         chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst    = 1'b0;
      clk_oe = 1'b1;
      op     = 2'd0;
      a      = '0;
      b      = '0;
      q      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_dn", {31'd0, dn}, 32'd0);
      chk("rst_dz", {31'd0, dz}, 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_outh", out_h, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("mulu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
             32'h00000001, 32'hFFFFFFFE, 1'b0);
      run_op("muls", 2'd1, 32'hFFFFFFFD, 32'd7, 0,
             32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
      run_op("divu", 2'd2, 32'd100, 32'd7, 0,
             32'd14, 32'd2, 1'b0);
      run_op("divs", 2'd3, 32'hFFFFFF9C, 32'd7, 0,
             32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
      run_op("divu_z", 2'd2, 32'd5, 32'd0, 0,
             32'hFFFFFFFF, 32'd5, 1'b1);
      run_op("divs_z", 2'd3, 32'hFFFFFFF6, 32'd0, 0,
             32'hFFFFFFFF, 32'hFFFFFFF6, 1'b1);
      run_op("divs_ovf", 2'd3, 32'h80000000, 32'hFFFFFFFF, 0,
             32'h80000000, 32'd0, 1'b0);
      run_op("muls_min", 2'd1, 32'h80000000, 32'd2, 0,
             32'h00000000, 32'hFFFFFFFF, 1'b0);
      run_op("q_toggle", 2'd2, 32'd1000, 32'd10, 1,
             32'd100, 32'd0, 1'b0);
      run_op("freeze", 2'd0, 32'd12345, 32'd1000, 2,
             32'd12345000, 32'd0, 1'b0);
      run_op("abort", 2'd0, 32'd9, 32'd9, 3,
             32'd0, 32'd0, 1'b0);
      run_op("post_rst", 2'd0, 32'd6, 32'd7, 0,
             32'd42, 32'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
